// File: rtl/shared_nibble_adder_sched.sv
// Two-requester round-robin scheduler around a single 4-bit ripple adder.
// Wide sums are built one nibble per clock, LSB nibble first.
module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c;

  always_comb begin
    sum = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module shared_nibble_adder_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH+3:0] sum_cat;
  logic             carry;
  logic             id_reg;
  logic [CW-1:0]    cnt;
  logic [3:0]       nsum;
  logic             ncout;
  logic             last_nib;

  always_comb begin
    grant = ~last_grant;
    unique case (1'b1)
      (req0_valid && !req1_valid): grant = 1'b0;
      (req1_valid && !req0_valid): grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && !rst && req1_valid && grant;
  assign accept = req0_ready | req1_ready;
  assign rsp_valid = (state == DONE);

  ripple_adder u_add (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nsum),
    .cout (ncout)
  );

  // New nibble enters at the top; after NIB shifts the LSB nibble is at bit 0.
  assign sum_cat = {nsum, sum_sh};
  assign sum_next = sum_cat[WIDTH+3:4];
  assign last_nib = (cnt == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      id_reg     <= 1'b0;
      cnt        <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= grant ? req1_a : req0_a;
            b_sh       <= grant ? req1_b : req0_b;
            carry      <= grant ? req1_cin : req0_cin;
            id_reg     <= grant;
            last_grant <= grant;
            cnt        <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_sh <= sum_next;
          carry  <= ncout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          cnt    <= cnt + CW'(1);
          if (last_nib) begin
            rsp_sum  <= sum_next;
            rsp_cout <= ncout;
            rsp_id   <= id_reg;
            state    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_nibble_adder_sched.sv
// Bench for shared_nibble_adder_sched: directed steps, queue scoreboard,
// WIDTH=16 main instance plus a WIDTH=8 instance.
module tb_shared_nibble_adder_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r0v, r0r, r0c, r1v, r1r, r1c;
  logic [15:0] r0a, r0b, r1a, r1b, rsum;
  logic        rv, rr, rcout, rid;

  logic       e0v, e0r, e0c, e1v, e1r, e1c;
  logic [7:0] e0a, e0b, e1a, e1b, esum;
  logic       ev, er, ecout, eid;

  shared_nibble_adder_sched #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a),
    .req0_b(r0b), .req0_cin(r0c),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a),
    .req1_b(r1b), .req1_cin(r1c),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_sum(rsum),
    .rsp_cout(rcout), .rsp_id(rid)
  );

  shared_nibble_adder_sched #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .req0_valid(e0v), .req0_ready(e0r), .req0_a(e0a),
    .req0_b(e0b), .req0_cin(e0c),
    .req1_valid(e1v), .req1_ready(e1r), .req1_a(e1a),
    .req1_b(e1b), .req1_cin(e1c),
    .rsp_valid(ev), .rsp_ready(er), .rsp_sum(esum),
    .rsp_cout(ecout), .rsp_id(eid)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        id;
  } exp_t;

  exp_t q[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [15:0] a,
                      input logic [15:0] b, input logic c);
    exp_t e;
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum = s[15:0];
    e.cout = s[16];
    e.id = id;
    q.push_back(e);
  endtask

  task automatic cmp_rsp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, {16'd0, rsum}, {16'd0, e.sum});
      chk({tag, "_cout"}, {31'd0, rcout}, {31'd0, e.cout});
      chk({tag, "_id"}, {31'd0, rid}, {31'd0, e.id});
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    if (rv) cmp_rsp(tag);
  endtask

  task automatic send(input string tag, input logic id,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    int n;
    if (id) begin
      r1v = 1'b1; r1a = a; r1b = b; r1c = c;
    end else begin
      r0v = 1'b1; r0a = a; r0b = b; r0c = c;
    end
    #1;
    n = 0;
    while (!(id ? r1r : r0r) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept_timeout"}, {31'd0, n < 20}, 32'd1);
    push(id, a, b, c);
    chk({tag, "_other_ready"}, {31'd0, id ? r0r : r1r}, 32'd0);
    tick();
    r0v = 1'b0;
    r1v = 1'b0;
    wait_rsp(tag);
  endtask

  initial begin
    int cyc, nacc, nrsp, n;
    int acc_cyc[4];
    r0v = 0; r0a = 0; r0b = 0; r0c = 0;
    r1v = 0; r1a = 0; r1b = 0; r1c = 0;
    rr = 1;
    e0v = 0; e0a = 0; e0b = 0; e0c = 0;
    e1v = 0; e1a = 0; e1b = 0; e1c = 0;
    er = 1;

    // Reset state
    tick();
    tick();
    r0v = 1'b1;
    r1v = 1'b1;
    #1;
    chk("rst_r0_ready", {31'd0, r0r}, 0);
    chk("rst_r1_ready", {31'd0, r1r}, 0);
    chk("rst_rsp_valid", {31'd0, rv}, 0);
    chk("rst_rsp_sum", {16'd0, rsum}, 0);
    chk("rst_rsp_cout", {31'd0, rcout}, 0);
    chk("rst_rsp_id", {31'd0, rid}, 0);
    r0v = 1'b0;
    r1v = 1'b0;
    rst = 1'b0;
    tick();

    send("t1", 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    chk("t1_abs_sum", {16'd0, rsum}, 32'h2233);
    send("t2", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk("t2_abs_sum", {16'd0, rsum}, 32'h0000);
    chk("t2_abs_cout", {31'd0, rcout}, 1);

    // Both requesters continuously valid from reset
    rst = 1'b1;
    r0a = 16'h0001; r0b = 16'h0002; r0c = 1'b0;
    r1a = 16'h8000; r1b = 16'h8000; r1c = 1'b1;
    r0v = 1'b1;
    r1v = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cyc = 0; nacc = 0; nrsp = 0;
    while (nrsp < 4 && cyc < 60) begin
      if (r0r && r1r) chk("rr_both_ready", 1, 0);
      if (r0r || r1r) begin
        chk("rr_grant_order", {31'd0, r1r}, nacc % 2);
        if (r1r) push(1'b1, r1a, r1b, r1c);
        else push(1'b0, r0a, r0b, r0c);
        if (nacc < 4) acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (rv) begin
        chk("rr_rsp_order", {31'd0, rid}, nrsp % 2);
        cmp_rsp("rr");
        nrsp++;
      end
      if (nrsp < 4) begin
        tick();
        cyc++;
      end
    end
    chk("rr_rsp_count", nrsp, 4);
    chk("rr_acc_count", nacc, 4);
    for (int i = 1; i < 4; i++)
      chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
    r0v = 1'b0;
    r1v = 1'b0;
    tick();

    // Consumer stall in DONE
    rr = 1'b0;
    send("stall", 1'b0, 16'h00F0, 16'h0F10, 1'b1);
    r1v = 1'b1; r1a = 16'h0005; r1b = 16'h0006; r1c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, rv}, 1);
      chk("stall_sum", {16'd0, rsum}, 32'h1001);
      chk("stall_cout", {31'd0, rcout}, 0);
      chk("stall_id", {31'd0, rid}, 0);
      chk("stall_readies", {30'd0, r0r, r1r}, 0);
    end
    rr = 1'b1;
    tick();
    chk("release_valid", {31'd0, rv}, 0);
    chk("release_idle", {31'd0, r1r}, 1);
    r1v = 1'b0;
    tick();

    // Reset mid-ADD after requester 0 wins
    r0v = 1'b1; r0a = 16'h1111; r0b = 16'h2222; r0c = 1'b0;
    #1;
    n = 0;
    while (!r0r && n < 20) begin
      tick();
      n++;
    end
    chk("mid_accept", {31'd0, r0r}, 1);
    tick();
    r0v = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    r0v = 1'b1;
    r1v = 1'b1;
    #1;
    chk("mid_rst_readies", {30'd0, r0r, r1r}, 0);
    chk("mid_rst_valid", {31'd0, rv}, 0);
    chk("mid_rst_sum", {16'd0, rsum}, 0);
    chk("mid_rst_cout", {31'd0, rcout}, 0);
    chk("mid_rst_id", {31'd0, rid}, 0);
    r0v = 1'b0;
    r1v = 1'b0;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rv) n++;
    end
    chk("mid_no_rsp", n, 0);
    r0v = 1'b1;
    r1v = 1'b1;
    #1;
    chk("mid_tie_r0", {31'd0, r0r}, 1);
    chk("mid_tie_r1", {31'd0, r1r}, 0);
    r1v = 1'b0;
    send("mid_after", 1'b0, 16'h1111, 16'h2222, 1'b0);
    tick();

    // WIDTH=8 instance
    e0v = 1'b1; e0a = 8'hAB; e0b = 8'h67; e0c = 1'b1;
    #1;
    chk("w8_ready", {31'd0, e0r}, 1);
    tick();
    e0v = 1'b0;
    n = 0;
    while (!ev && n < 20) begin
      tick();
      n++;
    end
    chk("w8_latency", n, 2);
    chk("w8_sum", {24'd0, esum}, 32'h13);
    chk("w8_cout", {31'd0, ecout}, 1);
    chk("w8_id", {31'd0, eid}, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
